// File: rtl/div_sequencer_if.sv
// Operand request and result handshakes between a client and the divider sequencer.
interface div_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor, out_ready,
    input  ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, out_ready,
    output ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_sequencer.sv
// Sequencer and trial-subtract datapath for a WIDTH-iteration restoring divider that
// drives an external 2*WIDTH-bit remainder register and registers the extracted result.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  div_sequencer_if.slave     bus,
  input  logic [2*WIDTH-1:0] Remainder_out,
  output logic               W_ctrl,
  output logic [WIDTH-1:0]   Dividend_in,
  output logic [WIDTH-1:0]   ALU_result,
  output logic               Carry
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAPT, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dvd, r_dsr;
  logic               r_valid;
  logic [WIDTH-1:0]   r_quo, r_rem;
  logic               r_dz;
  logic [WIDTH:0]     w_diff;
  logic               w_ready;
  logic               w_wctrl;

  // Extra top bit of the subtract is the borrow (upper half < divisor).
  assign w_diff      = {1'b0, Remainder_out[2*WIDTH-1:WIDTH]} - {1'b0, r_dsr};
  assign ALU_result  = w_diff[WIDTH-1:0];
  assign Carry       = w_diff[WIDTH];
  assign Dividend_in = r_dvd;
  assign W_ctrl      = w_wctrl;

  assign bus.ready       = w_ready;
  assign bus.out_valid   = r_valid;
  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dz;

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_wctrl = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.start) w_next = S_LOAD;
      end
      S_LOAD: w_next = S_RUN;
      S_RUN: begin
        w_wctrl = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_CAPT;
      end
      S_CAPT: w_next = S_DONE;
      S_DONE: if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_valid <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_dvd <= bus.dividend;
          r_dsr <= bus.divisor;
        end
        S_LOAD: r_cnt <= '0;
        S_RUN:  r_cnt <= r_cnt + 1'b1;
        S_CAPT: begin
          r_valid <= 1'b1;
          if (r_dsr == '0) begin
            r_quo <= '1;
            r_rem <= r_dvd;
            r_dz  <= 1'b1;
          end else begin
            // Remainder sits one place left of the upper half after the last shift.
            r_quo <= Remainder_out[WIDTH-1:0];
            r_rem <= {1'b0, Remainder_out[2*WIDTH-1:WIDTH+1]};
            r_dz  <= 1'b0;
          end
        end
        S_DONE: if (bus.out_ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// Randomized self-checking bench for div_sequencer, closing the loop with a model
// of the external remainder register and checking results against plain / and %.
module tb_div_sequencer;
  localparam int unsigned W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2*W-1:0]   rr = '0;
  logic             W_ctrl;
  logic [W-1:0]     Dividend_in;
  logic [W-1:0]     ALU_result;
  logic             Carry;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  div_sequencer_if #(.WIDTH(W)) bus();

  div_sequencer #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .Remainder_out (rr),
    .W_ctrl        (W_ctrl),
    .Dividend_in   (Dividend_in),
    .ALU_result    (ALU_result),
    .Carry         (Carry)
  );

  always #5 clk = ~clk;

  // Remainder register beside the sequencer: load shifted dividend, or shift with restore.
  always @(posedge clk) begin
    if (!W_ctrl)    rr <= {{(W-1){1'b0}}, Dividend_in, 1'b0};
    else if (Carry) rr <= rr << 1;
    else            rr <= {ALU_result[W-2:0], rr[W-1:0], 1'b1};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One division transaction. hold = cycles out_ready stays low after out_valid;
  // pulse = drive a spurious start with other operands while the divider is busy.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit pulse);
    logic [W-1:0] eq, er;
    logic         edz;
    int           k, n, wcnt;
    if (b == 0) begin eq = '1; er = a; edz = 1'b1; end
    else        begin eq = a / b; er = a % b; edz = 1'b0; end

    n = 0;
    while (!bus.ready && n < 100) begin @(negedge clk); n++; end
    check("ready_before_start", {63'd0, bus.ready}, 64'd1);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
    check("ready_after_accept", {63'd0, bus.ready}, 64'd0);

    // k counts clocks with the accept edge as clock 1.
    k = 1; wcnt = 0;
    while (!bus.out_valid && k < 200) begin
      if (W_ctrl) wcnt++;
      if (pulse && k == 10) begin
        bus.start = 1'b1; bus.dividend = ~a; bus.divisor = b + 1;
        check("ready_busy", {63'd0, bus.ready}, 64'd0);
      end
      if (pulse && k == 11) bus.start = 1'b0;
      @(negedge clk); k++;
    end
    check("latency", 64'(k), 64'(W + 3));
    check("wctrl_cycles", 64'(wcnt), 64'(W));
    check("dividend_in", 64'(Dividend_in), 64'(a));
    check("alu", {31'd0, Carry, ALU_result},
          {31'd0, (rr[2*W-1:W] < b), rr[2*W-1:W] - b});

    for (int i = 0; i <= hold; i++) begin
      check("quotient", 64'(bus.quotient), 64'(eq));
      check("remainder", 64'(bus.remainder), 64'(er));
      check("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, edz});
      check("valid_held", {62'd0, bus.out_valid, bus.ready}, 64'd2);
      if (i < hold) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("after_take", {62'd0, bus.out_valid, bus.ready}, 64'd1);
  endtask

  initial begin
    logic [W-1:0] a, b;
    int n;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {63'd0, bus.ready}, 64'd1);
    check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_wctrl", {63'd0, W_ctrl}, 64'd0);
    check("rst_results", {bus.quotient, bus.remainder}, 64'd0);
    check("rst_dz", {63'd0, bus.div_by_zero}, 64'd0);
    check("rst_dvd", 64'(Dividend_in), 64'd0);

    do_op(32'd100, 32'd7, 0, 1'b0);
    do_op(32'h1234, 32'd0, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op(32'd3, 32'd10, 0, 1'b0);
    do_op(32'd12345, 32'd77, 10, 1'b1);

    // Reset in the middle of RUN: no result may appear.
    bus.start = 1'b1; bus.dividend = 32'd999; bus.divisor = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    check("midrun_wctrl", {63'd0, W_ctrl}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ctl", {61'd0, bus.ready, W_ctrl, bus.out_valid}, 64'd4);
    n = 0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) n++; end
    check("rst_no_result", 64'(n), 64'd0);
    do_op(32'd50, 32'd5, 0, 1'b0);

    do_op(32'd1000, 32'd33, 0, 1'b0);
    do_op(32'd7, 32'd7, 0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: b = 32'($urandom_range(1, 65535));
        default: b = $urandom & 32'h7FFF_FFFF;
      endcase
      do_op(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
